// File: rtl/bubble_sort_n_if.sv
// Serial block-sorter bus: input word stream, output word stream and busy status.
interface bubble_sort_n_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic [WIDTH-1:0] data_serial_i;
  logic             data_valid_i;
  logic             data_ready_o;
  logic             descend_i;
  logic [WIDTH-1:0] data_serial_o;
  logic             data_valid_o;
  logic             data_ready_i;
  logic             busy_o;

  modport slave (
    input  data_serial_i, data_valid_i, descend_i, data_ready_i,
    output data_ready_o, data_serial_o, data_valid_o, busy_o
  );

  modport master (
    output data_serial_i, data_valid_i, descend_i, data_ready_i,
    input  data_ready_o, data_serial_o, data_valid_o, busy_o
  );
endinterface

// File: rtl/bubble_sort_n.sv
// Block sorter: loads DEPTH words serially, runs DEPTH odd-even transposition phases,
// then streams the sorted block out serially.
module bubble_sort_n #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 8,
  parameter bit          SIGNED = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  bubble_sort_n_if.slave  bus
);

  localparam int unsigned IW      = $clog2(DEPTH);
  localparam logic [IW-1:0] LastIdx = IW'(DEPTH - 1);

  typedef enum logic [1:0] {StLoad, StSort, StUnload} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    ph_q, ph_d;
  logic             desc_q, desc_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             ready, valid;

  function automatic logic greater(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  // Handshake outputs are forced idle while reset is held, whatever the state.
  always_comb begin
    ready             = ~rst && (state_q == StLoad);
    valid             = ~rst && (state_q == StUnload);
    bus.data_ready_o  = ready;
    bus.data_valid_o  = valid;
    bus.data_serial_o = valid ? mem_q[idx_q] : '0;
    bus.busy_o        = ~rst && ((state_q != StLoad) || (idx_q != '0));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ph_d    = ph_q;
    desc_d  = desc_q;
    mem_d   = mem_q;
    unique case (state_q)
      StLoad: begin
        if (bus.data_valid_i && ready) begin
          mem_d[idx_q] = bus.data_serial_i;
          if (idx_q == '0) desc_d = bus.descend_i;
          if (idx_q == LastIdx) begin
            state_d = StSort;
            idx_d   = '0;
            ph_d    = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StSort: begin
        // Pairs starting at even i on even phases, odd i on odd phases; pairs are disjoint.
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
          if (((i % 2) == 1) == ph_q[0]) begin
            if (desc_q ? greater(mem_q[i+1], mem_q[i]) : greater(mem_q[i], mem_q[i+1])) begin
              mem_d[i]   = mem_q[i+1];
              mem_d[i+1] = mem_q[i];
            end
          end
        end
        ph_d = ph_q + 1'b1;
        if (ph_q == LastIdx) begin
          state_d = StUnload;
          ph_d    = '0;
        end
      end
      StUnload: begin
        if (valid && bus.data_ready_i) begin
          if (idx_q == LastIdx) begin
            state_d = StLoad;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLoad;
      idx_q   <= '0;
      ph_q    <= '0;
      desc_q  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ph_q    <= ph_d;
      desc_q  <= desc_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_bubble_sort_n.sv
// Scoreboard bench for bubble_sort_n: three configurations, directed blocks with
// hand-computed sorted results, flow control, back-to-back blocks and reset mid-sort.
module tb_bubble_sort_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a  = 1'b1;
  logic rst_bc = 1'b1;

  bubble_sort_n_if #(.WIDTH(32)) ifa ();
  bubble_sort_n_if #(.WIDTH(8))  ifb ();
  bubble_sort_n_if #(.WIDTH(16)) ifc ();

  bubble_sort_n #(.WIDTH(32), .DEPTH(8), .SIGNED(1'b1)) dut_a (
    .clk(clk), .rst(rst_a), .bus(ifa.slave));
  bubble_sort_n #(.WIDTH(8), .DEPTH(5), .SIGNED(1'b0)) dut_b (
    .clk(clk), .rst(rst_bc), .bus(ifb.slave));
  bubble_sort_n #(.WIDTH(16), .DEPTH(7), .SIGNED(1'b1)) dut_c (
    .clk(clk), .rst(rst_bc), .bus(ifc.slave));

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_a[$];
  logic [7:0]  exp_b[$];
  logic [15:0] exp_c[$];

  bit rand_rdy = 1'b0;
  bit rand_gap = 1'b0;

  int a_v1[8] = '{5, -3, 7, 0, -3, 2, 9, 1};
  int a_e1[8] = '{-3, -3, 0, 1, 2, 5, 7, 9};
  int a_e2[8] = '{9, 7, 5, 2, 1, 0, -3, -3};
  int a_v3[8] = '{100, -50, 3, 3, 0, -1, 32'h7fff_ffff, 32'h8000_0000};
  int a_e3[8] = '{32'h8000_0000, -50, -1, 0, 3, 3, 100, 32'h7fff_ffff};
  int a_v4[8] = '{10, 20, 30, 40, 50, 60, 70, 80};
  int a_e4[8] = '{80, 70, 60, 50, 40, 30, 20, 10};
  int a_v5[8] = '{8, 1, 7, 2, 6, 3, 5, 4};
  int a_v6[8] = '{4, 3, 2, 1, 8, 7, 6, 5};
  int a_e6[8] = '{1, 2, 3, 4, 5, 6, 7, 8};

  logic [7:0]  b_v[5] = '{8'hFF, 8'h01, 8'h80, 8'h7F, 8'h00};
  logic [7:0]  b_e[5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
  logic [15:0] c_v[7] = '{16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
  logic [15:0] c_e[7] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h, required %0h at %0t", name, act, exp, $time);
  endtask

  task automatic put_a(input logic [31:0] w, input logic d);
    int g = 0;
    bit acc = 1'b0;
    if (rand_gap) begin
      repeat ($urandom_range(0, 2)) begin
        ifa.data_valid_i  = 1'b0;
        ifa.data_serial_i = 32'hdead_beef;
        @(posedge clk); #1;
      end
    end
    ifa.data_valid_i  = 1'b1;
    ifa.data_serial_i = w;
    ifa.descend_i     = d;
    do begin
      @(negedge clk);
      acc = ifa.data_ready_o;
      @(posedge clk); #1;
      g++;
    end while (!acc && g < 300);
    if (!acc) chk("a_load_timeout", 32'(acc), 32'd1);
    ifa.data_valid_i = 1'b0;
    ifa.descend_i    = 1'b0;
  endtask

  task automatic send_a(input int v[8], input bit d, input bit push, input int e[8]);
    if (push) for (int i = 0; i < 8; i++) exp_a.push_back(32'(e[i]));
    for (int i = 0; i < 8; i++) put_a(32'(v[i]), (i == 0) ? d : 1'b0);
  endtask

  task automatic drain_a();
    int g = 0;
    while (exp_a.size() != 0 && g < 2000) begin
      @(posedge clk);
      g++;
    end
    chk("a_drain", 32'(exp_a.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic put_b(input logic [7:0] w);
    int g = 0;
    bit acc = 1'b0;
    ifb.data_valid_i  = 1'b1;
    ifb.data_serial_i = w;
    do begin
      @(negedge clk);
      acc = ifb.data_ready_o;
      @(posedge clk); #1;
      g++;
    end while (!acc && g < 300);
    if (!acc) chk("b_load_timeout", 32'(acc), 32'd1);
    ifb.data_valid_i = 1'b0;
  endtask

  task automatic put_c(input logic [15:0] w);
    int g = 0;
    bit acc = 1'b0;
    ifc.data_valid_i  = 1'b1;
    ifc.data_serial_i = w;
    do begin
      @(negedge clk);
      acc = ifc.data_ready_o;
      @(posedge clk); #1;
      g++;
    end while (!acc && g < 300);
    if (!acc) chk("c_load_timeout", 32'(acc), 32'd1);
    ifc.data_valid_i = 1'b0;
  endtask

  // Consumer for the main instance; stalls randomly when rand_rdy is set.
  initial begin
    ifa.data_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      ifa.data_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  int          a_out_cnt = 0;
  bit          a_stall   = 1'b0;
  bit          a_chk_rdy = 1'b0;
  logic [31:0] a_hold    = '0;

  always @(negedge clk) begin
    if (rst_a) begin
      a_stall   = 1'b0;
      a_chk_rdy = 1'b0;
      a_out_cnt = 0;
    end else begin
      if (a_chk_rdy) begin
        chk("a_ready_after_block", 32'(ifa.data_ready_o), 32'd1);
        a_chk_rdy = 1'b0;
      end
      if (a_stall) begin
        chk("a_hold_valid", 32'(ifa.data_valid_o), 32'd1);
        chk("a_hold_stable", ifa.data_serial_o, a_hold);
      end
      if (!ifa.data_valid_o) chk("a_idle_zero", ifa.data_serial_o, 32'd0);
      if (ifa.data_valid_o && ifa.data_ready_i) begin
        if (exp_a.size() == 0) begin
          n_checks++;
          $display("FAIL a_unexpected_out: actual %0h, required no output at %0t",
                   ifa.data_serial_o, $time);
        end else begin
          chk("a_out", ifa.data_serial_o, exp_a.pop_front());
          a_out_cnt++;
          if (a_out_cnt == 8) begin
            a_out_cnt = 0;
            a_chk_rdy = 1'b1;
          end
        end
      end
      a_stall = ifa.data_valid_o && !ifa.data_ready_i;
      a_hold  = ifa.data_serial_o;
    end
  end

  always @(negedge clk) begin
    if (!rst_bc && ifb.data_valid_o && ifb.data_ready_i) begin
      if (exp_b.size() == 0) begin
        n_checks++;
        $display("FAIL b_unexpected_out: actual %0h, required no output", ifb.data_serial_o);
      end else begin
        chk("b_out", 32'(ifb.data_serial_o), 32'(exp_b.pop_front()));
      end
    end
    if (!rst_bc && ifc.data_valid_o && ifc.data_ready_i) begin
      if (exp_c.size() == 0) begin
        n_checks++;
        $display("FAIL c_unexpected_out: actual %0h, required no output", ifc.data_serial_o);
      end else begin
        chk("c_out", 32'(ifc.data_serial_o), 32'(exp_c.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int g;
    ifa.data_valid_i = 1'b0; ifa.data_serial_i = '0; ifa.descend_i = 1'b0;
    ifb.data_valid_i = 1'b0; ifb.data_serial_i = '0; ifb.descend_i = 1'b0;
    ifb.data_ready_i = 1'b1;
    ifc.data_valid_i = 1'b0; ifc.data_serial_i = '0; ifc.descend_i = 1'b0;
    ifc.data_ready_i = 1'b1;

    fork
      begin : main_a
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ifa.data_ready_o), 32'd0);
        chk("rst_valid", 32'(ifa.data_valid_o), 32'd0);
        chk("rst_busy", 32'(ifa.busy_o), 32'd0);
        chk("rst_data", ifa.data_serial_o, 32'd0);
        @(posedge clk); #1;
        rst_a = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(ifa.data_ready_o), 32'd1);
        @(posedge clk); #1;

        // Ascending, no stalls, with output latency measured from the last input edge.
        send_a(a_v1, 1'b0, 1'b1, a_e1);
        k = 1;
        @(negedge clk);
        while (!ifa.data_valid_o && k < 40) begin
          @(negedge clk);
          k++;
        end
        chk("a_latency", 32'(k), 32'd9);
        drain_a();

        send_a(a_v1, 1'b1, 1'b1, a_e2);
        drain_a();

        // Random input gaps and output stalls; two blocks loaded back-to-back.
        rand_gap = 1'b1;
        rand_rdy = 1'b1;
        send_a(a_v3, 1'b0, 1'b1, a_e3);
        send_a(a_v4, 1'b1, 1'b1, a_e4);
        drain_a();
        rand_gap = 1'b0;
        rand_rdy = 1'b0;
        @(posedge clk); #1;

        // Reset during the sort phase with ph = 3; the aborted block must never appear.
        send_a(a_v5, 1'b0, 1'b0, a_e1);
        @(negedge clk);
        chk("a_busy_sort", 32'(ifa.busy_o), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 32'(ifa.data_ready_o), 32'd0);
        chk("midrst_busy", 32'(ifa.busy_o), 32'd0);
        @(posedge clk); #1;
        rst_a = 1'b0;
        @(negedge clk);
        chk("after_rst_valid", 32'(ifa.data_valid_o), 32'd0);
        chk("after_rst_busy", 32'(ifa.busy_o), 32'd0);
        chk("after_rst_ready", 32'(ifa.data_ready_o), 32'd1);
        @(posedge clk); #1;
        send_a(a_v6, 1'b0, 1'b1, a_e6);
        drain_a();
      end
      begin : main_bc
        repeat (3) @(posedge clk);
        #1;
        rst_bc = 1'b0;
        for (int i = 0; i < 5; i++) exp_b.push_back(b_e[i]);
        for (int i = 0; i < 5; i++) put_b(b_v[i]);
        for (int i = 0; i < 7; i++) exp_c.push_back(c_e[i]);
        for (int i = 0; i < 7; i++) put_c(c_v[i]);
        for (int i = 0; i < 7; i++) exp_c.push_back(c_e[i]);
        for (int i = 0; i < 7; i++) put_c(c_e[i]);
        g = 0;
        while ((exp_b.size() != 0 || exp_c.size() != 0) && g < 2000) begin
          @(posedge clk);
          g++;
        end
        chk("b_drain", 32'(exp_b.size()), 32'd0);
        chk("c_drain", 32'(exp_c.size()), 32'd0);
      end
    join

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bubble_sort_n.md
# bubble_sort_n

Parametrised block sorter: accepts a block of DEPTH signed or unsigned WIDTH-bit words serially over a valid/ready handshake, sorts them in place with an odd-even transposition network, then streams the sorted block out serially over a valid/ready handshake. Sort direction is selectable per block. It sits between a serial producer and a serial consumer, taking the place of the fixed-size, fixed-direction serial sorter.
- Adds input and output flow control.
- Adds a deterministic DEPTH-cycle sort phase.

## Interface
- WIDTH, 32, data word width in bits (>= 2).
- DEPTH, 8, words per block (>= 2, odd or even).
- SIGNED, 1, 1 = two's-complement compare, 0 = unsigned compare.

- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- data_serial_i  in  WIDTH  input word.
- data_valid_i  in  1  input word present.
- data_ready_o  out  1  block can accept an input word.
- descend_i  in  1  0 = ascending, 1 = descending; sampled with the first word of each block.
- data_serial_o  out  WIDTH  sorted output word.
- data_valid_o  out  1  output word present.
- data_ready_i  in  1  consumer accepts output word.
- busy_o  out  1  a block is in progress (partial load, sort or unload).

## Operation
- Storage is DEPTH registers buf[0..DEPTH-1]. There is a load/unload index idx and a phase counter ph.
- FSM states are LOAD, SORT and UNLOAD.
- LOAD
  - data_ready_o = 1.
  - Input transfer occurs when data_valid_i & data_ready_o. On a transfer: buf[idx] <= data_serial_i; idx++.
  - On the transfer with idx == 0, latch desc <= descend_i.
  - On the transfer with idx == DEPTH-1: go to SORT, set idx <= 0 and ph <= 0.
- SORT
  - data_ready_o = 0 and data_valid_o = 0.
  - Each cycle, compare-exchange all disjoint pairs (i, i+1) in parallel:
    - even ph: i = 0, 2, 4, …
    - odd ph: i = 1, 3, 5, …
    - i+1 must be <= DEPTH-1.
  - Swap when buf[i] > buf[i+1] (desc = 0) or buf[i] < buf[i+1] (desc = 1).
  - Equal words are never swapped.
  - Comparison is signed when SIGNED = 1 and unsigned otherwise. No arithmetic beyond compare; width is preserved.
  - ph increments each cycle. The cycle with ph == DEPTH-1 is the last; then go to UNLOAD.
- UNLOAD
  - data_valid_o = 1 and data_serial_o = buf[idx].
  - Output transfer occurs when data_valid_o & data_ready_i; it increments idx.
  - Transfer with idx == DEPTH-1: go to LOAD, idx <= 0.
  - data_serial_o is held stable while data_valid_o & ~data_ready_i.
- data_serial_o = 0 whenever data_valid_o = 0.
- busy_o = (state != LOAD) | (idx != 0).
- descend_i is ignored except on the first accepted word. Changing it mid-block has no effect.
- data_valid_i while data_ready_o = 0 is ignored; the word is not captured.

## Timing
- While rst is high and on its edge:
  - state = LOAD, idx = 0, ph = 0, desc = 0, all buf = 0.
  - data_valid_o = 0, data_serial_o = 0, busy_o = 0.
  - data_ready_o = 0 while rst is high, 1 from the first cycle with rst low.
- Reset is allowed in any state, including mid-LOAD, mid-SORT and mid-UNLOAD. The current block is discarded; no partial output continues after reset.
- Last input transfer at edge t:
  - SORT occupies cycles t+1 … t+DEPTH.
  - data_valid_o first high in cycle t+DEPTH+1, with buf[0] = smallest (ascending) or largest (descending).
- Throughput without stalls: one block per 3·DEPTH cycles. LOAD and UNLOAD never overlap.
- Back-to-back blocks: in the cycle after the final output transfer, data_ready_o = 1.
- DEPTH phases guarantee a fully sorted result for any input, including reverse-sorted input.

## Test plan
- Ascending sort, WIDTH=32, DEPTH=8, SIGNED=1, descend_i=0, no stalls:
  - Stimulus: 5, -3, 7, 0, -3, 2, 9, 1.
  - Output: -3, -3, 0, 1, 2, 5, 7, 9.
  - data_valid_o first rises exactly 9 cycles after the last input transfer edge.
- Descending sort, same config and data, descend_i=1 on the first word and 0 afterwards:
  - Output: 9, 7, 5, 2, 1, 0, -3, -3.
- Unsigned compare, SIGNED=0, WIDTH=8, DEPTH=5:
  - Stimulus: 0xFF, 0x01, 0x80, 0x7F, 0x00.
  - Output: 0x00, 0x01, 0x7F, 0x80, 0xFF.
- Worst case and odd depth, DEPTH=7:
  - Stimulus: 7, 6, 5, 4, 3, 2, 1.
  - Output: 1 … 7.
  - An already-sorted block passes through unchanged.
- Flow control:
  - data_valid_i toggles randomly during load; only words with data_ready_o high are captured.
  - data_ready_i toggles randomly during unload; data_serial_o stays stable during stalls.
  - No word is lost or duplicated.
  - Two back-to-back blocks sort independently.
- Reset mid-SORT (ph = 3):
  - Next cycle: data_valid_o = 0, busy_o = 0, data_ready_o = 1.
  - A fresh block 4, 3, 2, 1, 8, 7, 6, 5 (DEPTH=8) then outputs 1 … 8 correctly.
